// File: rtl/freg_wb_arbiter.sv
// -----------------------------------------------------------------------------
// freg_wb_arbiter
//
// Write-back arbiter and busy scoreboard for the single-write-port FP register
// file. Two producers share the write port: the FPU result (src0) and the FLW
// load unit (src1). A granted request is registered and drives we/wa/wd one
// cycle later. A per-register busy vector gives issue logic RAW/WAW flags.
//
// Optional feature macro: FREG_WB_RR_EN
//   defined   : round-robin arbitration on conflict (1-bit priority pointer)
//   undefined : fixed priority, src0 always wins, no pointer register
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   s0_valid/ready/addr/data   FPU write-back request channel
//   s1_valid/ready/addr/data   load-unit write-back request channel
//   iss_set, iss_addr     issue marks iss_addr busy at the edge
//   ra0, ra1, ra2         source registers of the instruction in issue
//   hz_src[2:0]           bit i set when ra_i is busy (RAW)
//   hz_dst                iss_addr is busy (WAW); issue must stall on it
//   busy                  scoreboard vector, one bit per register
//   we, wa, wd            registered register-file write port
//
// Handshake: a request is transferred in any cycle where valid && ready are
// both high at the rising edge. ready is combinational, never asserts without
// valid, and at most one source is ready per cycle. A source that sees
// valid && !ready must hold valid, addr and data stable until accepted.
// -----------------------------------------------------------------------------
module freg_wb_arbiter #(
    parameter int SCALE = 5,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s0_valid,
    output logic                    s0_ready,
    input  logic [SCALE-1:0]        s0_addr,
    input  logic [WIDTH-1:0]        s0_data,
    input  logic                    s1_valid,
    output logic                    s1_ready,
    input  logic [SCALE-1:0]        s1_addr,
    input  logic [WIDTH-1:0]        s1_data,
    input  logic                    iss_set,
    input  logic [SCALE-1:0]        iss_addr,
    input  logic [SCALE-1:0]        ra0,
    input  logic [SCALE-1:0]        ra1,
    input  logic [SCALE-1:0]        ra2,
    output logic [2:0]              hz_src,
    output logic                    hz_dst,
    output logic [(1<<SCALE)-1:0]   busy,
    output logic                    we,
    output logic [SCALE-1:0]        wa,
    output logic [WIDTH-1:0]        wd
);

    localparam int NREG = 1 << SCALE;

    logic             grant0;
    logic             grant1;
    logic             grant;
    logic [SCALE-1:0] g_addr;
    logic [WIDTH-1:0] g_data;

    logic             we_q;
    logic [SCALE-1:0] wa_q;
    logic [WIDTH-1:0] wd_q;
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef FREG_WB_RR_EN
    // ptr_q = 0: src0 preferred on conflict, 1: src1 preferred.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant0 = s0_valid & (~s1_valid | ~ptr_q);
        grant1 = s1_valid & (~s0_valid |  ptr_q);
        ptr_d  = ptr_q;
        // Only a contested grant moves the pointer, so a lone requester
        // never steals the other's next turn.
        if (s0_valid & s1_valid) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant0 = s0_valid;
        grant1 = s1_valid & ~s0_valid;
    end
`endif

    always_comb begin
        grant  = grant0 | grant1;
        g_addr = grant1 ? s1_addr : s0_addr;
        g_data = grant1 ? s1_data : s0_data;
    end

    assign s0_ready = grant0;
    assign s1_ready = grant1;

    // -------------------------------------------------------------------------
    // Write stage: one cycle of latency; wa/wd hold when nothing is granted.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= grant;
            if (grant) begin
                wa_q <= g_addr;
                wd_q <= g_data;
            end
        end
    end

    assign we = we_q;
    assign wa = wa_q;
    assign wd = wd_q;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[wa_q] = 1'b0;
        end
        // Applied after the clear: a new producer issued to the register that
        // is committing right now keeps it busy.
        if (iss_set) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    // A register committing this cycle is not hazardous: the register file
    // forwards wd during its own write cycle.
    always_comb begin
        hz_src[0] = busy_q[ra0]      & ~(we_q & (wa_q == ra0));
        hz_src[1] = busy_q[ra1]      & ~(we_q & (wa_q == ra1));
        hz_src[2] = busy_q[ra2]      & ~(we_q & (wa_q == ra2));
        hz_dst    = busy_q[iss_addr] & ~(we_q & (wa_q == iss_addr));
    end

endmodule

// File: tb/tb_freg_wb_arbiter.sv
module tb_freg_wb_arbiter;

    localparam int SCALE = 5;
    localparam int WIDTH = 32;
    localparam int NREG  = 32;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             s0_valid, s0_ready, s1_valid, s1_ready;
    logic [SCALE-1:0] s0_addr, s1_addr, iss_addr, ra0, ra1, ra2, wa;
    logic [WIDTH-1:0] s0_data, s1_data, wd;
    logic             iss_set, hz_dst, we;
    logic [2:0]       hz_src;
    logic [NREG-1:0]  busy;

    freg_wb_arbiter #(.SCALE(SCALE), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .iss_set(iss_set), .iss_addr(iss_addr),
        .ra0(ra0), .ra1(ra1), .ra2(ra2),
        .hz_src(hz_src), .hz_dst(hz_dst), .busy(busy),
        .we(we), .wa(wa), .wd(wd)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic drive_idle();
        s0_valid = 0; s0_addr = '0; s0_data = '0;
        s1_valid = 0; s1_addr = '0; s1_data = '0;
        iss_set  = 0; iss_addr = '0;
        ra0 = '0; ra1 = '0; ra2 = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        logic             s0v;
        logic [SCALE-1:0] s0a;
        logic [WIDTH-1:0] s0d;
        logic             s1v;
        logic [SCALE-1:0] s1a;
        logic [WIDTH-1:0] s1d;
        logic             iss;
        logic [SCALE-1:0] issa;
        logic [SCALE-1:0] r0, r1, r2;
        logic             e_r0, e_r1;
        logic [2:0]       e_hs;
        logic             e_hd;
        logic             e_we;
        logic [SCALE-1:0] e_wa;
        logic [WIDTH-1:0] e_wd;
        logic [NREG-1:0]  e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(
        input logic s0v, input logic [4:0] s0a, input logic [31:0] s0d,
        input logic s1v, input logic [4:0] s1a, input logic [31:0] s1d,
        input logic iss, input logic [4:0] issa,
        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
        input logic e_r0, input logic e_r1, input logic [2:0] e_hs, input logic e_hd,
        input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic [31:0] e_busy);
        vec_t v;
        v.s0v = s0v; v.s0a = s0a; v.s0d = s0d;
        v.s1v = s1v; v.s1a = s1a; v.s1d = s1d;
        v.iss = iss; v.issa = issa; v.r0 = r0; v.r1 = r1; v.r2 = r2;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_hs = e_hs; v.e_hd = e_hd;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    localparam logic [31:0] DA = 32'hAAAA0006;
    localparam logic [31:0] DB = 32'hBBBB0007;
    localparam logic [31:0] DC = 32'hCCCC0008;
    localparam logic [31:0] DD = 32'hDDDD0009;
    localparam logic [31:0] PI = 32'h40490FDB;

    task automatic fill_table();
        //   s0v s0a s0d            s1v s1a s1d  iss issa r0 r1 r2  er0 er1 ehs    ehd  ewe ewa ewd            ebusy
        add(0, 0, 0,              0, 0, 0,    1, 3,   0, 0, 0,  0, 0, 3'b000, 0,   0, 0, 0,              32'h1 << 3);
        add(1, 3, 32'h3F000000,   0, 0, 0,    0, 3,   0, 3, 0,  1, 0, 3'b010, 1,   1, 3, 32'h3F000000,   32'h1 << 3);
        add(0, 0, 0,              0, 0, 0,    0, 3,   0, 3, 0,  0, 0, 3'b000, 0,   0, 3, 32'h3F000000,   32'h0);
        add(0, 0, 0,              0, 0, 0,    1, 2,   0, 0, 0,  0, 0, 3'b000, 0,   0, 3, 32'h3F000000,   32'h1 << 2);
        add(0, 0, 0,              1, 2, PI,   0, 2,   0, 2, 0,  0, 1, 3'b010, 1,   1, 2, PI,             32'h1 << 2);
        add(0, 0, 0,              0, 0, 0,    0, 2,   2, 2, 2,  0, 0, 3'b000, 0,   0, 2, PI,             32'h0);
        add(0, 0, 0,              0, 0, 0,    1, 5,   0, 0, 0,  0, 0, 3'b000, 0,   0, 2, PI,             32'h1 << 5);
        add(1, 5, 32'h11111111,   0, 0, 0,    0, 0,   0, 0, 5,  1, 0, 3'b100, 0,   1, 5, 32'h11111111,   32'h1 << 5);
        // set and clear of register 5 collide: set wins
        add(0, 0, 0,              0, 0, 0,    1, 5,   0, 0, 0,  0, 0, 3'b000, 0,   0, 5, 32'h11111111,   32'h1 << 5);
        // four contested cycles
        add(1, 6, DA,             1, 7, DB,   0, 0,   0, 0, 0,  1, 0, 3'b000, 0,   1, 6, DA,             32'h1 << 5);
`ifdef FREG_WB_RR_EN
        add(1, 6, DA,             1, 7, DB,   0, 0,   0, 0, 0,  0, 1, 3'b000, 0,   1, 7, DB,             32'h1 << 5);
        add(1, 6, DA,             1, 7, DB,   0, 0,   0, 0, 0,  1, 0, 3'b000, 0,   1, 6, DA,             32'h1 << 5);
        add(1, 6, DA,             1, 7, DB,   0, 0,   0, 0, 0,  0, 1, 3'b000, 0,   1, 7, DB,             32'h1 << 5);
        add(0, 0, 0,              0, 0, 0,    0, 0,   0, 0, 0,  0, 0, 3'b000, 0,   0, 7, DB,             32'h1 << 5);
`else
        add(1, 6, DA,             1, 7, DB,   0, 0,   0, 0, 0,  1, 0, 3'b000, 0,   1, 6, DA,             32'h1 << 5);
        add(1, 6, DA,             1, 7, DB,   0, 0,   0, 0, 0,  1, 0, 3'b000, 0,   1, 6, DA,             32'h1 << 5);
        add(1, 6, DA,             1, 7, DB,   0, 0,   0, 0, 0,  1, 0, 3'b000, 0,   1, 6, DA,             32'h1 << 5);
        add(0, 0, 0,              0, 0, 0,    0, 0,   0, 0, 0,  0, 0, 3'b000, 0,   0, 6, DA,             32'h1 << 5);
`endif
        // lone src1 grant, then a conflict that src0 wins in both builds
        add(0, 0, 0,              1, 8, DC,   0, 0,   0, 0, 0,  0, 1, 3'b000, 0,   1, 8, DC,             32'h1 << 5);
        add(1, 9, DD,             1, 8, DC,   0, 0,   0, 0, 0,  1, 0, 3'b000, 0,   1, 9, DD,             32'h1 << 5);
        add(0, 0, 0,              0, 0, 0,    0, 0,   0, 0, 0,  0, 0, 3'b000, 0,   0, 9, DD,             32'h1 << 5);
    endtask

    // ---------------------------------------------------------------- reference model
    logic [NREG-1:0]  m_busy;
    logic             m_we;
    logic [SCALE-1:0] m_wa;
    logic [WIDTH-1:0] m_wd;
    int               m_conf;
    logic [SCALE+WIDTH-1:0] exp_q[$];

    // Grant pair {g1, g0}: contested cycles alternate starting with src0 in
    // the round-robin build, counted since the last reset.
    function automatic logic [1:0] model_grant(input logic v0, input logic v1, input int nconf);
        if (v0 && v1) begin
`ifdef FREG_WB_RR_EN
            return (nconf % 2 == 0) ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return {v1 & ~v0, v0};
    endfunction

    function automatic logic model_hz(input logic [SCALE-1:0] a);
        return m_busy[a] && !(m_we && m_wa == a);
    endfunction

    task automatic model_clear();
        m_busy = '0; m_we = 0; m_wa = '0; m_wd = '0; m_conf = 0;
        exp_q.delete();
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        logic [1:0] g;
        logic       hold0, hold1;
        logic [SCALE+WIDTH-1:0] e;

        rst_n = 1'b0;
        drive_idle();
        do_reset();

        // reset state
        chk("rst_we",    we,    1'b0);
        chk("rst_wa",    wa,    '0);
        chk("rst_wd",    wd,    '0);
        chk("rst_busy",  busy,  '0);
        chk("rst_ready", {s1_ready, s0_ready}, 2'b00);
        chk("rst_hz",    {hz_dst, hz_src}, 4'b0000);

        // directed table
        fill_table();
        for (int i = 0; i < tbl.size(); i++) begin
            s0_valid = tbl[i].s0v; s0_addr = tbl[i].s0a; s0_data = tbl[i].s0d;
            s1_valid = tbl[i].s1v; s1_addr = tbl[i].s1a; s1_data = tbl[i].s1d;
            iss_set = tbl[i].iss; iss_addr = tbl[i].issa;
            ra0 = tbl[i].r0; ra1 = tbl[i].r1; ra2 = tbl[i].r2;
            @(negedge clk);
            chk($sformatf("tbl%0d_s0_ready", i), s0_ready, tbl[i].e_r0);
            chk($sformatf("tbl%0d_s1_ready", i), s1_ready, tbl[i].e_r1);
            chk($sformatf("tbl%0d_hz_src", i),   hz_src,   tbl[i].e_hs);
            chk($sformatf("tbl%0d_hz_dst", i),   hz_dst,   tbl[i].e_hd);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_we", i),   we,   tbl[i].e_we);
            chk($sformatf("tbl%0d_wa", i),   wa,   tbl[i].e_wa);
            chk($sformatf("tbl%0d_wd", i),   wd,   tbl[i].e_wd);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
        end

        // reset asserted while a write is pending
        drive_idle();
        s0_valid = 1; s0_addr = 5'd4; s0_data = 32'h12345678;
        iss_set = 1; iss_addr = 5'd4;
        @(posedge clk);
        #1;
        chk("midrst_pre_we",   we,   1'b1);
        chk("midrst_pre_busy", busy, (32'h1 << 5) | (32'h1 << 4));
        iss_set = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we",   we,   1'b0);
        chk("midrst_busy", busy, '0);
        chk("midrst_wa",   wa,   '0);
        chk("midrst_wd",   wd,   '0);
        @(posedge clk);
        #1;
        chk("midrst_hold_we", we, 1'b0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_we",   we,   1'b0);
        chk("postrst_busy", busy, '0);
        s0_valid = 1; s0_addr = 5'd10; s0_data = 32'hCAFE0010;
        s1_valid = 1; s1_addr = 5'd11; s1_data = 32'hCAFE0011;
        @(negedge clk);
        chk("postrst_ptr", {s1_ready, s0_ready}, 2'b01);
        @(posedge clk);
        #1;
        chk("postrst_wa", wa, 5'd10);

        // randomized phase against the model
        do_reset();
        model_clear();
        hold0 = 0; hold1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!hold0) begin
                s0_valid = 1'($urandom_range(0, 1));
                s0_addr  = 5'($urandom_range(0, 7));
                s0_data  = $urandom;
            end
            if (!hold1) begin
                s1_valid = 1'($urandom_range(0, 1));
                s1_addr  = 5'($urandom_range(0, 7));
                s1_data  = $urandom;
            end
            ra0 = 5'($urandom_range(0, 7));
            ra1 = 5'($urandom_range(0, 7));
            ra2 = 5'($urandom_range(0, 7));
            iss_addr = 5'($urandom_range(0, 7));
            iss_set  = ($urandom_range(0, 2) == 0) && !model_hz(iss_addr);
            @(negedge clk);
            g = model_grant(s0_valid, s1_valid, m_conf);
            chk("rnd_ready",  {s1_ready, s0_ready}, g);
            chk("rnd_hz_src", hz_src, {model_hz(ra2), model_hz(ra1), model_hz(ra0)});
            chk("rnd_hz_dst", hz_dst, model_hz(iss_addr));
            if (g[0]) exp_q.push_back({s0_addr, s0_data});
            else if (g[1]) exp_q.push_back({s1_addr, s1_data});
            if (m_we) m_busy[m_wa] = 1'b0;
            if (iss_set) m_busy[iss_addr] = 1'b1;
            if (s0_valid && s1_valid) m_conf++;
            hold0 = s0_valid && !g[0];
            hold1 = s1_valid && !g[1];
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_we = 1'b1;
                m_wa = e[SCALE+WIDTH-1:WIDTH];
                m_wd = e[WIDTH-1:0];
            end else begin
                m_we = 1'b0;
            end
            chk("rnd_we",   we,   m_we);
            chk("rnd_wa",   wa,   m_wa);
            chk("rnd_wd",   wd,   m_wd);
            chk("rnd_busy", busy, m_busy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
